// File: rtl/tc_pl_cap_gain_autorange.sv
`default_nettype none
// ============================================================================
//  Module   : tc_pl_cap_gain_autorange
//  Purpose  : Gain-decision stage ahead of the capture-channel relay latch.
//             Measures peak |ADC| over a window of valid samples and picks
//             one of four gain steps (auto) or applies manual_idx (manual).
//             Each gain change is written to the relay stage with a
//             one-cycle gset_en, acknowledged by gset_relay_cmpt, and then
//             followed by a relay-settle hold-off.
//  Ports    :
//    clk, rst          - clock, asynchronous active-high reset
//    enable            - block runs while high; low returns to IDLE
//    mode_manual       - 1: use manual_idx, 0: autorange
//    manual_idx        - manual gain index
//    thr_hi / thr_lo   - unsigned peak thresholds (step down / step up)
//    win_len           - valid samples per window (0 acts as 1)
//    settle_len        - relay settle cycles (0 acts as 1)
//    adc_data/adc_valid- signed sample and strobe
//    gset_en           - one-cycle relay write request
//    gset_relay        - relay code, held between writes
//    gset_relay_cmpt   - relay write acknowledge
//    gain_idx          - applied gain index
//    range_lock        - current gain accepted
//    range_busy        - relay change or settle in progress
//    overrange         - last window clipped at lowest gain
//    cmpt_err          - sticky acknowledge timeout
//  Revision : 1.0 - initial release
// ============================================================================
module tc_pl_cap_gain_autorange #(
    parameter int                   ADC_W      = 16,
    parameter int                   CAP0_14    = 4,
    parameter logic [4*CAP0_14-1:0] GAIN_TABLE = 16'h8421,
    parameter int                   CMPT_TO    = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic                     mode_manual,
    input  logic [1:0]               manual_idx,
    input  logic [ADC_W-1:0]         thr_hi,
    input  logic [ADC_W-1:0]         thr_lo,
    input  logic [15:0]              win_len,
    input  logic [15:0]              settle_len,
    input  logic signed [ADC_W-1:0]  adc_data,
    input  logic                     adc_valid,
    output logic                     gset_en,
    output logic [CAP0_14-1:0]       gset_relay,
    input  logic                     gset_relay_cmpt,
    output logic [1:0]               gain_idx,
    output logic                     range_lock,
    output logic                     range_busy,
    output logic                     overrange,
    output logic                     cmpt_err
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        REQ       = 3'd1,
        WAIT_CMPT = 3'd2,
        SETTLE    = 3'd3,
        MEASURE   = 3'd4,
        DECIDE    = 3'd5,
        LOCK      = 3'd6
    } state_t;

    localparam logic [ADC_W-1:0] c_adc_min   = {1'b1, {(ADC_W-1){1'b0}}};
    localparam logic [ADC_W-1:0] c_adc_max   = {1'b0, {(ADC_W-1){1'b1}}};
    localparam logic [15:0]      c_cmpt_last = 16'(CMPT_TO - 1);

    state_t               r_state;
    state_t               w_next;
    logic [1:0]           w_target;
    logic [CAP0_14-1:0]   w_relay_code;

    logic [1:0]           r_gain_idx;
    logic [CAP0_14-1:0]   r_gset_relay;
    logic                 r_gset_en;
    logic                 r_range_lock;
    logic                 r_range_busy;
    logic                 r_overrange;
    logic                 r_cmpt_err;
    logic [15:0]          r_cnt;
    logic [ADC_W-1:0]     r_peak;

    logic [ADC_W-1:0]     w_abs;
    logic                 w_hi;
    logic                 w_lo;
    logic                 w_settle_done;
    logic                 w_win_done;
    logic                 w_cmpt_timeout;
    logic [15:0]          w_cnt_inc;

    // |sample|; the most negative code has no positive twin, so it clips.
    always_comb begin
        w_abs = adc_data;
        if (adc_data == c_adc_min) begin
            w_abs = c_adc_max;
        end else if (adc_data[ADC_W-1]) begin
            w_abs = -adc_data;
        end
    end

    assign w_hi           = (r_peak > thr_hi);
    assign w_lo           = (r_peak < thr_lo);
    assign w_cnt_inc      = r_cnt + 16'd1;
    // Compared one count ahead so a length of 0 still behaves as 1.
    assign w_settle_done  = ({1'b0, r_cnt} + 17'd1) >= {1'b0, settle_len};
    assign w_win_done     = ({1'b0, r_cnt} + 17'd1) >= {1'b0, win_len};
    // r_cnt starts at 0 in REQ, so this fires CMPT_TO cycles after gset_en.
    assign w_cmpt_timeout = (r_cnt >= c_cmpt_last);

    always_comb begin
        w_relay_code = GAIN_TABLE[int'(w_target)*CAP0_14 +: CAP0_14];
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Next state and target gain
    // ------------------------------------------------------------------
    always_comb begin
        w_next   = r_state;
        w_target = r_gain_idx;
        if (!enable) begin
            w_next = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!r_cmpt_err) begin
                        w_target = mode_manual ? manual_idx : r_gain_idx;
                        w_next   = REQ;
                    end
                end
                REQ: w_next = WAIT_CMPT;
                WAIT_CMPT: begin
                    if (gset_relay_cmpt) begin
                        w_next = SETTLE;
                    end else if (w_cmpt_timeout) begin
                        w_next = IDLE;
                    end
                end
                SETTLE: begin
                    if (w_settle_done) begin
                        w_next = mode_manual ? LOCK : MEASURE;
                    end
                end
                MEASURE: begin
                    if (adc_valid && w_win_done) begin
                        w_next = DECIDE;
                    end
                end
                DECIDE: begin
                    // Overload check first: clipping wins over a misconfigured thr_lo.
                    if (w_hi && (r_gain_idx != 2'd0)) begin
                        w_target = r_gain_idx - 2'd1;
                        w_next   = REQ;
                    end else if (w_hi) begin
                        w_next = MEASURE;
                    end else if (w_lo && (r_gain_idx != 2'd3)) begin
                        w_target = r_gain_idx + 2'd1;
                        w_next   = REQ;
                    end else begin
                        w_next = MEASURE;
                    end
                end
                LOCK: begin
                    if (!mode_manual) begin
                        w_target = r_gain_idx;
                        w_next   = REQ;
                    end else if (manual_idx != r_gain_idx) begin
                        w_target = manual_idx;
                        w_next   = REQ;
                    end
                end
                default: w_next = IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Datapath and status registers. Relay code, index and gset_en are
    // loaded on the edge entering REQ so they are coherent during REQ.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gain_idx   <= 2'd0;
            r_gset_relay <= GAIN_TABLE[CAP0_14-1:0];
            r_gset_en    <= 1'b0;
            r_range_lock <= 1'b0;
            r_range_busy <= 1'b0;
            r_overrange  <= 1'b0;
            r_cmpt_err   <= 1'b0;
            r_cnt        <= 16'd0;
            r_peak       <= '0;
        end else begin
            r_gset_en <= 1'b0;
            if (!enable) begin
                r_range_lock <= 1'b0;
                r_range_busy <= 1'b0;
                r_overrange  <= 1'b0;
                r_cmpt_err   <= 1'b0;
            end else if (w_next == REQ) begin
                r_gain_idx   <= w_target;
                r_gset_relay <= w_relay_code;
                r_gset_en    <= 1'b1;
                r_range_busy <= 1'b1;
                r_range_lock <= 1'b0;
                r_cnt        <= 16'd0;
            end else begin
                case (r_state)
                    REQ: r_cnt <= w_cnt_inc;
                    WAIT_CMPT: begin
                        if (gset_relay_cmpt) begin
                            r_cnt <= 16'd0;
                        end else if (w_cmpt_timeout) begin
                            r_cmpt_err   <= 1'b1;
                            r_range_busy <= 1'b0;
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                    SETTLE: begin
                        if (w_settle_done) begin
                            r_range_busy <= 1'b0;
                            r_cnt        <= 16'd0;
                            r_peak       <= '0;
                            if (mode_manual) begin
                                r_range_lock <= 1'b1;
                            end
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                    MEASURE: begin
                        if (adc_valid) begin
                            if (w_abs > r_peak) begin
                                r_peak <= w_abs;
                            end
                            r_cnt <= w_cnt_inc;
                        end
                    end
                    DECIDE: begin
                        // Only the no-change outcomes reach here.
                        r_range_lock <= 1'b1;
                        r_overrange  <= w_hi;
                        r_cnt        <= 16'd0;
                        r_peak       <= '0;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign gset_en    = r_gset_en;
    assign gset_relay = r_gset_relay;
    assign gain_idx   = r_gain_idx;
    assign range_lock = r_range_lock;
    assign range_busy = r_range_busy;
    assign overrange  = r_overrange;
    assign cmpt_err   = r_cmpt_err;

endmodule
`default_nettype wire

// File: tb/tb_tc_pl_cap_gain_autorange.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tc_pl_cap_gain_autorange
//  Purpose  : Directed self-checking bench for tc_pl_cap_gain_autorange.
//             A relay-stage responder logs every write and acknowledges one
//             cycle after gset_en when acknowledgement is switched on.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_tc_pl_cap_gain_autorange;

    localparam int ADC_W   = 16;
    localparam int CAP_W   = 4;
    localparam int CMPT_TO = 16;

    logic               clk;
    logic               rst;
    logic               enable;
    logic               mode_manual;
    logic [1:0]         manual_idx;
    logic [ADC_W-1:0]   thr_hi;
    logic [ADC_W-1:0]   thr_lo;
    logic [15:0]        win_len;
    logic [15:0]        settle_len;
    logic signed [ADC_W-1:0] adc_data;
    logic               adc_valid;
    logic               gset_en;
    logic [CAP_W-1:0]   gset_relay;
    logic               gset_relay_cmpt;
    logic [1:0]         gain_idx;
    logic               range_lock;
    logic               range_busy;
    logic               overrange;
    logic               cmpt_err;

    int n_checks;
    int n_fail;
    int wr_log[$];
    bit ack_on;
    bit ack_pend;

    tc_pl_cap_gain_autorange #(
        .ADC_W      (ADC_W),
        .CAP0_14    (CAP_W),
        .GAIN_TABLE (16'h8421),
        .CMPT_TO    (CMPT_TO)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .enable          (enable),
        .mode_manual     (mode_manual),
        .manual_idx      (manual_idx),
        .thr_hi          (thr_hi),
        .thr_lo          (thr_lo),
        .win_len         (win_len),
        .settle_len      (settle_len),
        .adc_data        (adc_data),
        .adc_valid       (adc_valid),
        .gset_en         (gset_en),
        .gset_relay      (gset_relay),
        .gset_relay_cmpt (gset_relay_cmpt),
        .gain_idx        (gain_idx),
        .range_lock      (range_lock),
        .range_busy      (range_busy),
        .overrange       (overrange),
        .cmpt_err        (cmpt_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Relay-stage model: logs writes, acks one cycle after gset_en.
    initial begin
        gset_relay_cmpt = 1'b0;
        ack_pend        = 1'b0;
        forever begin
            @(negedge clk);
            gset_relay_cmpt = ack_pend;
            ack_pend        = 1'b0;
            if (gset_en === 1'b1) begin
                wr_log.push_back(int'(gset_relay));
                if (ack_on) ack_pend = 1'b1;
            end
        end
    end

    task automatic wait_gset_en(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (gset_en === 1'b1) break;
        end
        chk_val("gset_en_seen", gset_en, 1);
    endtask

    task automatic wait_lock_idx(input logic [1:0] idx, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (range_lock === 1'b1 && gain_idx === idx) break;
        end
        chk_val("lock_reached", range_lock, 1);
        chk_val("lock_idx", gain_idx, idx);
    endtask

    task automatic wait_overrange(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (overrange === 1'b1) break;
        end
        chk_val("overrange_set", overrange, 1);
    endtask

    task automatic drop_enable();
        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int n_wr;
        int cyc;
        bit lock_dropped;

        n_checks    = 0;
        n_fail      = 0;
        ack_on      = 1'b1;
        rst         = 1'b1;
        enable      = 1'b0;
        mode_manual = 1'b0;
        manual_idx  = 2'd0;
        thr_hi      = 16'd30000;
        thr_lo      = 16'd1000;
        win_len     = 16'd8;
        settle_len  = 16'd10;
        adc_data    = 16'sd100;
        adc_valid   = 1'b1;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_val("rst_relay", gset_relay, 4'h1);
        chk_val("rst_idx", gain_idx, 0);
        chk_val("rst_en", gset_en, 0);
        chk_val("rst_flags", {range_lock, range_busy, overrange, cmpt_err}, 4'b0000);

        // 1: autorange climbs 0->3 with small samples
        enable = 1'b1;
        wait_lock_idx(2'd3, 400);
        chk_val("t1_nwr", wr_log.size(), 4);
        if (wr_log.size() == 4) begin
            chk_val("t1_wr0", wr_log[0], 1);
            chk_val("t1_wr1", wr_log[1], 2);
            chk_val("t1_wr2", wr_log[2], 4);
            chk_val("t1_wr3", wr_log[3], 8);
        end
        chk_val("t1_relay", gset_relay, 4'h8);
        chk_val("t1_busy", range_busy, 0);
        lock_dropped = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (range_lock !== 1'b1) lock_dropped = 1'b1;
        end
        chk_val("t1_lock_held", lock_dropped, 0);
        chk_val("t1_no_rewrite", wr_log.size(), 4);

        // 2: full-scale negative sample steps gain down to 2
        adc_data = -16'sd32768;
        @(negedge clk);
        @(negedge clk);
        adc_data = 16'sd100;
        wait_gset_en(40);
        chk_val("t2_lock_req", range_lock, 0);
        chk_val("t2_busy_req", range_busy, 1);
        chk_val("t2_relay", gset_relay, 4'h4);
        chk_val("t2_idx", gain_idx, 2);

        // 3: loud signal walks down to idx 0 then flags overrange
        adc_data = 16'sd32000;
        wait_overrange(500);
        chk_val("t3_idx", gain_idx, 0);
        chk_val("t3_lock", range_lock, 1);
        chk_val("t3_relay", gset_relay, 4'h1);
        n_wr = wr_log.size();
        repeat (40) @(negedge clk);
        chk_val("t3_no_write", wr_log.size(), n_wr);
        chk_val("t3_ovr_held", overrange, 1);
        adc_data = 16'sd5000;
        repeat (40) @(negedge clk);
        chk_val("t3_ovr_clear", overrange, 0);
        chk_val("t3_lock_mid", range_lock, 1);

        // enable low clears status, holds relay/index
        drop_enable();
        chk_val("dis_flags", {range_lock, range_busy, overrange, cmpt_err}, 4'b0000);
        chk_val("dis_relay", gset_relay, 4'h1);
        chk_val("dis_idx", gain_idx, 0);

        // 4: manual mode
        mode_manual = 1'b1;
        manual_idx  = 2'd2;
        enable      = 1'b1;
        wait_lock_idx(2'd2, 100);
        chk_val("t4_relay2", gset_relay, 4'h4);
        chk_val("t4_busy", range_busy, 0);
        n_wr = wr_log.size();
        manual_idx = 2'd1;
        wait_lock_idx(2'd1, 100);
        chk_val("t4_relay1", gset_relay, 4'h2);
        chk_val("t4_one_write", wr_log.size(), n_wr + 1);

        // 5: no acknowledge -> timeout
        drop_enable();
        ack_on     = 1'b0;
        manual_idx = 2'd3;
        enable     = 1'b1;
        wait_gset_en(10);
        cyc = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (cmpt_err === 1'b1) begin
                cyc = i;
                break;
            end
        end
        chk_val("t5_timeout_cyc", cyc, CMPT_TO);
        chk_val("t5_relay", gset_relay, 4'h8);
        n_wr = wr_log.size();
        repeat (20) @(negedge clk);
        chk_val("t5_no_restart", wr_log.size(), n_wr);
        chk_val("t5_err_sticky", cmpt_err, 1);
        drop_enable();
        chk_val("t5_err_clear", cmpt_err, 0);

        // 6a: drop enable during SETTLE
        ack_on     = 1'b1;
        manual_idx = 2'd1;
        enable     = 1'b1;
        wait_gset_en(10);
        @(negedge clk);
        @(negedge clk);
        chk_val("t6_busy_settle", range_busy, 1);
        enable = 1'b0;
        @(negedge clk);
        chk_val("t6_busy_off", range_busy, 0);
        chk_val("t6_lock_off", range_lock, 0);
        chk_val("t6_relay_held", gset_relay, 4'h2);
        chk_val("t6_idx_held", gain_idx, 1);
        chk_val("t6_no_en", gset_en, 0);

        // 6b: asynchronous reset during MEASURE
        mode_manual = 1'b0;
        win_len     = 16'd100;
        enable      = 1'b1;
        wait_gset_en(10);
        repeat (20) @(negedge clk);
        chk_val("t6_meas_busy", range_busy, 0);
        chk_val("t6_meas_idx", gain_idx, 1);
        #1 rst = 1'b1;
        #1;
        chk_val("t6_arst_relay", gset_relay, 4'h1);
        chk_val("t6_arst_idx", gain_idx, 0);
        chk_val("t6_arst_flags", {gset_en, range_lock, range_busy, overrange, cmpt_err}, 5'b00000);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
